// File: rtl/uart_transmitter_controller.sv
// UART transmit engine: start bit, 8 data bits LSB-first, optional even parity, one stop bit,
// each bit held for 16 pulses of Tx_sample_ENABLE. Define UART_TX_PARITY_EN to add the parity bit.
module uart_transmitter_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_sample_ENABLE,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic [2:0] dbg_state
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_e;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        boundary;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // A bit ends on the edge carrying its 16th tick.
  assign boundary = Tx_sample_ENABLE && (tick_q == 4'd15);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (Tx_sample_ENABLE) tick_d = tick_q + 4'd1;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (Tx_EN && Tx_WR) begin
          shift_d = Tx_DATA;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^Tx_DATA;
`endif
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (boundary) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            txd_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (boundary) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (boundary) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TxD       = txd_q;
  assign Tx_BUSY   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Bench for uart_transmitter_controller: directed frames, expected line bits queued per frame
// and checked tick-by-tick by an independent monitor.
module tb_uart_transmitter_controller;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       reset;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       Tx_sample_ENABLE;
  logic       TxD;
  logic       Tx_BUSY;
  logic [2:0] dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int idle_err   = 0;
  logic tick_run = 1'b1;

  logic [FB-1:0] exp_q[$];

  uart_transmitter_controller dut (
    .clk              (clk),
    .reset            (reset),
    .Tx_EN            (Tx_EN),
    .Tx_WR            (Tx_WR),
    .Tx_DATA          (Tx_DATA),
    .Tx_sample_ENABLE (Tx_sample_ENABLE),
    .TxD              (TxD),
    .Tx_BUSY          (Tx_BUSY),
    .dbg_state        (dbg_state)
  );

  // clock / tick generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    Tx_sample_ENABLE = 1'b0;
    forever begin
      @(negedge clk);
      div++;
      Tx_sample_ENABLE = tick_run && (div % 4 == 0);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [FB-1:0] make_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {p & 1'b0 | 1'b1, d, 1'b0};
`endif
  endfunction

  // driver tasks
  task automatic send(input logic [7:0] d, input logic p);
    @(negedge clk);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    exp_q.push_back(make_frame(d, p));
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (Tx_sample_ENABLE) k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Tx_BUSY && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n < 3000), 1);
  endtask

  // monitor / scoreboard
  logic [FB-1:0] cur;
  int   c;
  logic in_frame, busy_prev, tick_seen, bit_bad, bad_val;

  initial begin
    in_frame  = 1'b0;
    busy_prev = 1'b0;
    c = 0;
    bit_bad = 1'b0;
    bad_val = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk);
      tick_seen = Tx_sample_ENABLE;
      #1;
      if (!reset) begin
        in_frame  = 1'b0;
        busy_prev = 1'b0;
      end else if (!in_frame) begin
        if (Tx_BUSY && !busy_prev) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got Tx_BUSY=1, expected no frame (t=%0t)", $time);
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            c = 0;
            bit_bad = (TxD !== cur[0]);
            bad_val = TxD;
          end
        end else if (Tx_BUSY || TxD !== 1'b1) begin
          idle_err++;
        end
        busy_prev = Tx_BUSY;
      end else begin
        if (tick_seen) begin
          c++;
          if (c % 16 == 0) begin
            vectors++;
            if (bit_bad) begin
              miscompares++;
              $display("FAIL frame_bit%0d: got TxD=%0b/busy drop, expected TxD=%0b for 16 ticks (t=%0t)",
                       c / 16 - 1, bad_val, cur[c/16-1], $time);
            end
            bit_bad = 1'b0;
          end
        end
        if (c == FB * 16) begin
          check("busy_fall_txd", {30'd0, Tx_BUSY, TxD}, 1);
          in_frame = 1'b0;
        end else if (!Tx_BUSY || TxD !== cur[c/16]) begin
          bit_bad = 1'b1;
          bad_val = TxD;
        end
        busy_prev = Tx_BUSY;
      end
    end
  end

  // directed stimulus
  initial begin
    reset   = 1'b0;
    Tx_EN   = 1'b0;
    Tx_WR   = 1'b0;
    Tx_DATA = 8'h00;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      Tx_WR   = 1'($urandom_range(0, 1));
      Tx_EN   = 1'($urandom_range(0, 1));
      Tx_DATA = 8'($urandom_range(0, 255));
      #1;
      check("reset_hold", {30'd0, Tx_BUSY, TxD}, 1);
    end
    @(negedge clk);
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("post_reset_idle", {29'd0, dbg_state, Tx_BUSY, TxD} , 1);

    send(8'h55, 1'b0);
    wait_idle("wait_55");

    send(8'h07, 1'b1);
    wait_ticks(40);
    tick_run = 1'b0;
    repeat (40) @(negedge clk);
    check("hold_no_tick_busy", int'(Tx_BUSY), 1);
    tick_run = 1'b1;
    wait_idle("wait_07");

    send(8'h00, 1'b0);
    wait_idle("wait_00");
    send(8'hFF, 1'b0);
    wait_idle("wait_ff");

    // write while busy, held as a level until the frame ends
    send(8'h3C, 1'b0);
    wait_ticks(50);
    @(negedge clk);
    Tx_DATA = 8'hAA;
    Tx_WR   = 1'b1;
    exp_q.push_back(make_frame(8'hAA, 1'b0));
    wait_idle("wait_3c");
    @(negedge clk);
    Tx_WR = 1'b0;
    check("back_to_back_accept", int'(Tx_BUSY), 1);
    Tx_DATA = 8'h5A;
    wait_idle("wait_aa");

    @(negedge clk);
    Tx_EN   = 1'b0;
    Tx_WR   = 1'b1;
    Tx_DATA = 8'h12;
    repeat (30) @(negedge clk);
    check("en_low_no_accept", int'(Tx_BUSY), 0);
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;

    send(8'hD0, 1'b1);
    wait_ticks(40);
    Tx_EN = 1'b0;
    wait_idle("wait_d0");
    Tx_EN = 1'b1;

    send(8'h81, 1'b0);
    wait_ticks(88);
    check("bit4_state_data", int'(dbg_state), 2);
    #1 reset = 1'b0;
    #1 check("async_reset", {29'd0, dbg_state, Tx_BUSY, TxD}, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h81, 1'b0);
    wait_idle("wait_81");

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("idle_line_errors", idle_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_controller.md
# uart_transmitter_controller

UART transmit engine serialising one byte per request onto `TxD` as start bit, eight data bits LSB-first, optional even-parity bit and one stop bit. Each bit is held for 16 pulses of `Tx_sample_ENABLE`, the 16x oversampling tick the baud controller also supplies to the receiver. Sits between the host-side write interface and the serial line, mirroring the receiver's sample and bit counters on the transmit side.

## Interface
- No parameters; frame format fixed at 8 data bits, 16 ticks per bit.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `Tx_EN` input 1: transmitter enable; gates acceptance of new writes only.
- `Tx_WR` input 1: write strobe, single-cycle or level; sampled each `clk`.
- `Tx_DATA` input 8: byte to send; sampled only on the accepting edge.
- `Tx_sample_ENABLE` input 1: 16x baud tick, one `clk` wide per pulse.
- `TxD` output 1: serial line, idle high.
- `Tx_BUSY` output 1: high from acceptance until stop bit completes.

## Operation
- Reset values: `TxD`=1, `Tx_BUSY`=0, state IDLE, tick counter 0, bit counter 0, shift register 0x00, parity 0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: `TxD`=1. If `Tx_EN`=1 and `Tx_WR`=1: latch `Tx_DATA` into shift register, clear counters, go START, set `Tx_BUSY`.
- Tick counter: 4-bit, increments only on `clk` edges with `Tx_sample_ENABLE`=1; wraps 15 -> 0. Bit boundary = edge where counter is 15 and tick is high.
- START: `TxD`=0; at bit boundary go DATA, bit counter 0.
- DATA: `TxD` = shift register bit 0; at each bit boundary shift right by one, increment 3-bit bit counter; at boundary with bit counter 7 go PARITY (macro) or STOP.
- PARITY: `TxD` = XOR of all 8 latched data bits (even parity); at boundary go STOP.
- STOP: `TxD`=1; at boundary go IDLE, clear `Tx_BUSY`.
- `Tx_WR` while `Tx_BUSY`=1: ignored, no queuing; `Tx_DATA` changes mid-frame have no effect.
- `Tx_EN` deasserted mid-frame: current frame completes unchanged; no new acceptance while low.
- `Tx_sample_ENABLE` absent: state and `TxD` hold indefinitely.
- `reset` asserted mid-frame: immediately `TxD`=1, `Tx_BUSY`=0, IDLE; no partial frame resumes.

## Timing
- Acceptance edge E: `Tx_BUSY`=1 and `TxD`=0 visible after E (one-cycle latency from `Tx_WR`).
- Each bit lasts exactly 16 ticks; `TxD` changes on the same edge as the 16th tick.
- Frame length: 160 ticks (no parity) or 176 ticks (parity); `Tx_BUSY` falls on the edge of the final tick.
- Back-to-back: `Tx_WR` on the cycle after `Tx_BUSY` falls is accepted; stop bit is never shortened.
- `Tx_WR` coincident with the final stop-bit tick: not accepted (still busy on that edge).

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present, even-parity bit sent between bit 7 and stop, 11-bit frame.
- Undefined: PARITY state and parity logic absent, DATA goes directly to STOP, 10-bit frame.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `TxD`=1, `Tx_BUSY`=0 throughout; release, no activity without `Tx_WR`.
- Single frame 0x55, ticks every 4 clocks -> `TxD` sequence 0,1,0,1,0,1,0,1,0,[0 parity],1, each 16 ticks; `Tx_BUSY` high for 160/176 ticks exactly.
- Parity build, 0x07 -> parity bit 1; 0x00 -> parity bit 0; 0xFF -> parity bit 0.
- Write while busy: `Tx_WR` with 0xAA mid-frame of 0x3C -> line carries only 0x3C; next write after `Tx_BUSY` falls sends 0xAA with full start bit.
- `Tx_EN`=0 at IDLE with `Tx_WR`=1 -> no frame; `Tx_EN` dropped during DATA -> frame completes intact.
- `reset` pulsed low during bit 4 of 0x81 -> `TxD`=1, `Tx_BUSY`=0 asynchronously; subsequent write of 0x81 produces a clean full frame.
